fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter register.
- Issues one outstanding instruction-memory request at a time and delivers fetched instructions to decode through a valid/ready IF/ID output register.
- Drives the PC register's enable and write data: PC+4 on each delivered instruction, or the redirect target on a branch/jump flush.
- One-entry hold buffer absorbs a response that arrives while decode is stalled.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/addr_adder.sv | 13 +
 rtl/fetch_hold_buf.sv | 35 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
// Latency: none, types and constants only. Backpressure: not applicable.
package fetch_unit_pkg;

  localparam int          ADDR_SIZE         = 32;
  localparam int          WORD_LEN          = 32;
  localparam logic [31:0] FETCH_RESET_ADDR  = 32'h8000_0000;
  localparam int          FETCH_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/addr_adder.sv
// Modulo-2^W address adder; the carry out is dropped, so wrap is silent.
// Latency: combinational. Backpressure: not applicable.
module addr_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer, written when a response arrives while IF/ID is full.
// Latency: data visible the cycle after load. Backpressure: clear wins over load, load over unload.
module fetch_hold_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [ADDR_W-1:0] entry_pc,
  input  logic [DATA_W-1:0] entry_instr,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= entry_pc;
      instr <= entry_instr;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, valid/ready IF/ID register, drives the PC.
// Latency: request N, response N+1, if_valid N+2. Backpressure: a response during a decode stall parks in the hold buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W      = ADDR_SIZE,
  parameter int              DATA_W      = WORD_LEN,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(FETCH_RESET_ADDR),
  parameter int              INSTR_BYTES = FETCH_INSTR_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_wdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  input  logic              id_ready
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_fetch;
  logic              drop_flag;
  logic              slot_free;
  logic              req_fire;
  logic              resp_in_wait;
  logic              deliver_resp;
  logic              deliver_hold;
  logic              hold_load;
  logic              enter_req;
  logic              hb_valid;
  logic [ADDR_W-1:0] hb_pc;
  logic [DATA_W-1:0] hb_instr;

  addr_adder #(.W(ADDR_W)) u_pc_inc (
    .a   (pc),
    .b   (ADDR_W'(INSTR_BYTES)),
    .sum (pc_inc)
  );

  fetch_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (hold_load),
    .unload      (deliver_hold),
    .clear       (redirect_valid),
    .entry_pc    (req_addr),
    .entry_instr (imem_resp_data),
    .valid       (hb_valid),
    .pc          (hb_pc),
    .instr       (hb_instr)
  );

  assign slot_free    = !if_valid || id_ready;
  assign req_fire     = (state == REQ) && imem_req_ready;
  assign resp_in_wait = (state == WAIT) && imem_resp_valid;

  // A redirect squashes every delivery path, including the parked entry.
  assign deliver_resp = resp_in_wait && slot_free && !redirect_valid;
  assign hold_load    = resp_in_wait && !slot_free && !redirect_valid;
  assign deliver_hold = (state == HOLD) && hb_valid && id_ready && !redirect_valid;

  assign pc_en      = redirect_valid || deliver_resp || deliver_hold;
  assign pc_wdata   = redirect_valid ? redirect_target : pc_inc;
  assign next_fetch = pc_en ? pc_wdata : pc;

  assign enter_req = (resp_in_wait && (redirect_valid || slot_free))
                  || ((state == HOLD) && (redirect_valid || deliver_hold))
                  || ((state == DROP) && imem_resp_valid);

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = req_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= REQ;
      req_addr  <= RESET_ADDR;
      drop_flag <= 1'b0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= '0;
    end else begin
      if (deliver_resp) begin
        if_valid <= 1'b1;
        if_pc    <= req_addr;
        if_instr <= imem_resp_data;
      end else if (deliver_hold) begin
        if_valid <= 1'b1;
        if_pc    <= hb_pc;
        if_instr <= hb_instr;
      end else if (redirect_valid || id_ready) begin
        if_valid <= 1'b0;
      end

      if (enter_req) begin
        state     <= REQ;
        req_addr  <= next_fetch;
        drop_flag <= 1'b0;
      end else begin
        case (state)
          // An unaccepted request stays on the bus unchanged; a redirect only marks it squashed.
          REQ: begin
            if (req_fire) begin
              state <= (redirect_valid || drop_flag) ? DROP : WAIT;
            end else if (redirect_valid) begin
              drop_flag <= 1'b1;
            end
          end
          WAIT: begin
            if (hold_load) begin
              state <= HOLD;
            end else if (redirect_valid) begin
              state <= DROP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus randomized traffic, checked against a program-order fetch model.
// Memory and PC register are modelled in the bench.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  // memory model: one pending response with a countdown
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          resp_delay;

  // program-order model
  logic [31:0] exp_pc;
  int          deliveries;
  logic        prev_hold;
  logic [31:0] prev_addr;

  // per-cycle samples
  logic        s_if_valid, s_pc_en, s_req_valid;
  logic [31:0] s_if_pc, s_if_instr, s_pc_wdata, s_req_addr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_en           (pc_en),
    .pc_wdata        (pc_wdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .id_ready        (id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (prev_hold) begin
      chk1("req_stable_valid", imem_req_valid, 1'b1);
      chk("req_stable_addr", imem_req_addr, prev_addr);
    end
    if (redirect_valid) begin
      chk1("redir_pc_en", pc_en, 1'b1);
      chk("redir_pc_wdata", pc_wdata, redirect_target);
      exp_pc = redirect_target;
    end else begin
      if (pc_en) chk("seq_pc_wdata", pc_wdata, pc + 32'd4);
      if (if_valid && id_ready) begin
        chk("deliver_pc", if_pc, exp_pc);
        chk("deliver_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      if (mem_pend) chk1("single_outstanding", mem_pend, 1'b0);
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = resp_delay;
    end
    prev_hold = imem_req_valid && !imem_req_ready;
    prev_addr = imem_req_addr;
  endtask

  // Called just after a falling edge; applies inputs, samples, then advances one cycle.
  task automatic tick(input logic rr, input logic ir, input logic rv, input logic [31:0] rt);
    imem_req_ready  = rr;
    id_ready        = ir;
    redirect_valid  = rv;
    redirect_target = rt;
    if (mem_pend && mem_cnt == 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_addr);
      mem_pend        = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_pend) mem_cnt--;
    end
    #1;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_instr  = if_instr;
    s_pc_en     = pc_en;
    s_pc_wdata  = pc_wdata;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    if (reset) begin
      monitor();
    end else begin
      prev_hold = 1'b0;
      exp_pc    = RST_PC;
    end
    @(negedge clk);
    if (reset && s_pc_en) pc = s_pc_wdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pc    = RST_PC;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    mem_pend = 1'b0;
    reset    = 1'b1;
  endtask

  initial begin
    logic        rv;
    logic [31:0] rt;
    pc = RST_PC;
    redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    id_ready = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0; resp_delay = 1;
    exp_pc = RST_PC; deliveries = 0; prev_hold = 1'b0; prev_addr = '0;
    @(negedge clk);

    // reset state
    do_reset();
    chk1("rst_if_valid", s_if_valid, 1'b0);
    chk("rst_if_pc", s_if_pc, 32'h0);
    chk("rst_if_instr", s_if_instr, 32'h0);
    chk1("rst_pc_en", s_pc_en, 1'b0);
    chk1("rst_req_valid", s_req_valid, 1'b1);
    chk("rst_req_addr", s_req_addr, RST_PC);

    // back-to-back single-cycle memory
    resp_delay = 1;
    tick(1, 1, 0, 0);
    chk1("seq_c0_ifv", s_if_valid, 1'b0); chk("seq_c0_addr", s_req_addr, RST_PC);
    tick(1, 1, 0, 0);
    chk1("seq_c1_ifv", s_if_valid, 1'b0); chk1("seq_c1_pcen", s_pc_en, 1'b1);
    chk("seq_c1_wdata", s_pc_wdata, 32'h8000_0004);
    tick(1, 1, 0, 0);
    chk1("seq_c2_ifv", s_if_valid, 1'b1); chk("seq_c2_ifpc", s_if_pc, RST_PC);
    chk("seq_c2_instr", s_if_instr, mem_word(RST_PC)); chk("seq_c2_addr", s_req_addr, 32'h8000_0004);
    tick(1, 1, 0, 0);
    chk1("seq_c3_ifv", s_if_valid, 1'b0); chk("seq_c3_wdata", s_pc_wdata, 32'h8000_0008);
    tick(1, 1, 0, 0);
    chk1("seq_c4_ifv", s_if_valid, 1'b1); chk("seq_c4_ifpc", s_if_pc, 32'h8000_0004);

    // decode stall pushes the second response into the hold buffer
    do_reset();
    resp_delay = 1;
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 0);
      chk1("stall_ifv", s_if_valid, 1'b1); chk("stall_ifpc", s_if_pc, RST_PC);
      chk1("stall_pcen", s_pc_en, 1'b0);
    end
    tick(1, 1, 0, 0);
    chk1("unhold_pcen", s_pc_en, 1'b1); chk("unhold_wdata", s_pc_wdata, 32'h8000_0008);
    tick(1, 1, 0, 0);
    chk("unhold_ifpc", s_if_pc, 32'h8000_0004); chk1("unhold_pcen_once", s_pc_en, 1'b0);
    chk("unhold_next_addr", s_req_addr, 32'h8000_0008);

    // redirect while waiting; the late response is dropped
    do_reset();
    resp_delay = 3;
    tick(1, 1, 0, 0);
    resp_delay = 1;
    tick(1, 1, 1, 32'h8000_0100);
    tick(1, 1, 0, 0);
    chk1("rw_c2_ifv", s_if_valid, 1'b0); chk1("rw_c2_reqv", s_req_valid, 1'b0);
    tick(1, 1, 0, 0);
    chk1("rw_c3_ifv", s_if_valid, 1'b0);
    tick(1, 1, 0, 0);
    chk("rw_c4_addr", s_req_addr, 32'h8000_0100); chk1("rw_c4_ifv", s_if_valid, 1'b0);
    tick(1, 1, 0, 0);
    chk1("rw_c5_ifv", s_if_valid, 1'b0);
    tick(1, 1, 0, 0);
    chk1("rw_c6_ifv", s_if_valid, 1'b1); chk("rw_c6_ifpc", s_if_pc, 32'h8000_0100);
    chk("rw_c6_instr", s_if_instr, mem_word(32'h8000_0100));

    // redirect against an unaccepted request
    do_reset();
    resp_delay = 1;
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h8000_0100);
    tick(1, 1, 0, 0);
    chk("rq_old_addr", s_req_addr, RST_PC); chk1("rq_old_valid", s_req_valid, 1'b1);
    tick(1, 1, 0, 0);
    chk1("rq_drop_ifv", s_if_valid, 1'b0);
    tick(1, 1, 0, 0);
    chk("rq_new_addr", s_req_addr, 32'h8000_0100);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("rq_ifpc", s_if_pc, 32'h8000_0100);

    // PC wrap from the top of the address space
    do_reset();
    resp_delay = 1;
    tick(1, 1, 1, 32'hFFFF_FFFC);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("wrap_req_addr", s_req_addr, 32'hFFFF_FFFC);
    tick(1, 1, 0, 0);
    chk("wrap_wdata", s_pc_wdata, 32'h0);
    tick(1, 1, 0, 0);
    chk("wrap_next_addr", s_req_addr, 32'h0); chk("wrap_ifpc", s_if_pc, 32'hFFFF_FFFC);

    // reset during WAIT with the response landing inside reset
    do_reset();
    resp_delay = 1;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    resp_delay = 2;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk1("mid_pre_ifv", s_if_valid, 1'b1);
    do_reset();
    chk1("mid_rst_ifv", s_if_valid, 1'b0); chk("mid_rst_ifpc", s_if_pc, 32'h0);
    chk("mid_rst_instr", s_if_instr, 32'h0); chk1("mid_rst_pcen", s_pc_en, 1'b0);
    chk("mid_rst_addr", s_req_addr, RST_PC);
    resp_delay = 1;
    tick(1, 1, 0, 0);
    chk1("mid_c0_ifv", s_if_valid, 1'b0); chk("mid_c0_addr", s_req_addr, RST_PC);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk1("mid_c2_ifv", s_if_valid, 1'b1); chk("mid_c2_ifpc", s_if_pc, RST_PC);

    // randomized traffic against the program-order model
    do_reset();
    deliveries = 0;
    for (int i = 0; i < 4000; i++) begin
      resp_delay = $urandom_range(1, 3);
      rv = ($urandom_range(0, 99) < 4);
      rt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'hFFFF_FFFC);
      tick(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70), rv, rt);
    end
    chk1("liveness", deliveries > 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
